// File: rtl/btn_conditioner.sv
// Raw button conditioner: two-flop synchronizer, counter debounce, registered press pulses and move decode.
// Optional per-channel auto-repeat is compiled in with the BTN_AUTOREPEAT_EN macro.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 100000,
    parameter int unsigned RPT_DELAY = 5000000,
    parameter int unsigned RPT_RATE  = 1000000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_center,
    input  logic btn_up,
    input  logic btn_down,
    output logic center_lvl,
    output logic up_lvl,
    output logic down_lvl,
    output logic center_pulse,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_move,
    output logic down_move
);

    localparam int NCH = 3;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);

    // channel order: [0] center, [1] up, [2] down
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [NCH-1:0] lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0] rise_s;
    logic [CNT_W-1:0] dcnt_q [NCH];
    logic [CNT_W-1:0] dcnt_d [NCH];
    logic up_move_q, up_move_d, down_move_q, down_move_d;

    assign raw_s  = {btn_down, btn_up, btn_center};
    assign rise_s = lvl_q & ~lvl_prev_q;

    // Synchronizer shift, debounce counters and accepted levels
    always_comb begin
        s1_d       = raw_s;
        s2_d       = s1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q;
        for (int i = 0; i < NCH; i++) begin
            dcnt_d[i] = CNT_ZERO;
            if (s2_q[i] == lvl_q[i]) begin
                dcnt_d[i] = CNT_ZERO;
            end else if (dcnt_q[i] == DB_LAST) begin
                lvl_d[i]  = s2_q[i];
                dcnt_d[i] = CNT_ZERO;
            end else begin
                dcnt_d[i] = dcnt_q[i] + CNT_ONE;
            end
        end
    end

    // Move decode: opposing requests cancel each other
    always_comb begin
        up_move_d   = lvl_q[1] & ~lvl_q[2];
        down_move_d = lvl_q[2] & ~lvl_q[1];
    end

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    localparam logic [CNT_W-1:0] RPT_DELAY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST  = CNT_W'(RPT_RATE - 1);

    rpt_state_e     state_q [NCH];
    rpt_state_e     state_d [NCH];
    logic [CNT_W-1:0] rcnt_q [NCH];
    logic [CNT_W-1:0] rcnt_d [NCH];

    // Auto-repeat next state; a released button always drops back to idle silently
    always_comb begin
        pulse_d = 3'b000;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            if (!lvl_q[i]) begin
                state_d[i] = ST_IDLE;
                rcnt_d[i]  = CNT_ZERO;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (rise_s[i]) begin
                            pulse_d[i] = 1'b1;
                            state_d[i] = ST_DELAY;
                            rcnt_d[i]  = CNT_ZERO;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q[i] == RPT_DELAY_LAST) begin
                            pulse_d[i] = 1'b1;
                            state_d[i] = ST_REPEAT;
                            rcnt_d[i]  = CNT_ZERO;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q[i] == RPT_RATE_LAST) begin
                            pulse_d[i] = 1'b1;
                            rcnt_d[i]  = CNT_ZERO;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        rcnt_d[i]  = CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Auto-repeat state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                rcnt_q[i]  <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
        end
    end
`else
    // One pulse per accepted press
    always_comb begin
        pulse_d = rise_s;
    end
`endif

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 3'b000;
            s2_q        <= 3'b000;
            lvl_q       <= 3'b000;
            lvl_prev_q  <= 3'b000;
            pulse_q     <= 3'b000;
            up_move_q   <= 1'b0;
            down_move_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                dcnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_prev_d;
            pulse_q     <= pulse_d;
            up_move_q   <= up_move_d;
            down_move_q <= down_move_d;
            for (int i = 0; i < NCH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign center_lvl   = lvl_q[0];
    assign up_lvl       = lvl_q[1];
    assign down_lvl     = lvl_q[2];
    assign center_pulse = pulse_q[0];
    assign up_pulse     = pulse_q[1];
    assign down_pulse   = pulse_q[2];
    assign up_move      = up_move_q;
    assign down_move    = down_move_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: vector table, corner sequences and random stimulus
// compared every cycle against a sliding-window reference model.
module tb_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b000;
    logic center_lvl, up_lvl, down_lvl;
    logic center_pulse, up_pulse, down_pulse;
    logic up_move, down_move;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_RATE(RR), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_center(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]),
        .center_lvl(center_lvl), .up_lvl(up_lvl), .down_lvl(down_lvl),
        .center_pulse(center_pulse), .up_pulse(up_pulse), .down_pulse(down_pulse),
        .up_move(up_move), .down_move(down_move)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw samples per edge, accepted level, how long it has been held high
    bit       hist [3][16];
    logic [2:0] m_lvl;
    logic [2:0] m_pulse;
    logic     m_up_move, m_down_move;
    int       hold [3];

    typedef struct {
        bit         rst;
        logic [2:0] b;
        int         n;
        logic [2:0] lvl;
        logic [1:0] mv;
        int         upp;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 16; k++) hist[c][k] = 1'b0;
            hold[c] = 0;
        end
        m_lvl = 3'b000;
        m_pulse = 3'b000;
        m_up_move = 1'b0;
        m_down_move = 1'b0;
    endtask

    // A level flips once the last DB synchronized samples all disagree with it
    task automatic model_edge();
        logic [2:0] old;
        bit flip;
        int d;
        if (!rst_n) begin
            model_reset();
        end else begin
            old = m_lvl;
            for (int c = 0; c < 3; c++) begin
                d = hold[c] - 1;
                m_pulse[c] = old[c] && (d == 0 || (AR && d >= RD && ((d - RD) % RR) == 0));
            end
            m_up_move   = old[1] & ~old[2];
            m_down_move = old[2] & ~old[1];
            for (int c = 0; c < 3; c++) begin
                flip = 1'b1;
                for (int k = 1; k <= DB; k++) begin
                    if (hist[c][k] == old[c]) flip = 1'b0;
                end
                if (flip) m_lvl[c] = ~old[c];
                hold[c] = m_lvl[c] ? hold[c] + 1 : 0;
                for (int k = 15; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = btn[c];
            end
        end
    endtask

    task automatic compare_all();
        check("center_lvl", center_lvl, m_lvl[0]);
        check("up_lvl", up_lvl, m_lvl[1]);
        check("down_lvl", down_lvl, m_lvl[2]);
        check("center_pulse", center_pulse, m_pulse[0]);
        check("up_pulse", up_pulse, m_pulse[1]);
        check("down_pulse", down_pulse, m_pulse[2]);
        check("up_move", up_move, m_up_move);
        check("down_move", down_move, m_down_move);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int cnt;
        int pc;
        bit expp;
        model_reset();

        tbl[0]  = '{1'b0, 3'b111, 3, 3'b000, 2'b00, 0};
        tbl[1]  = '{1'b1, 3'b010, 5, 3'b000, 2'b00, 0};
        tbl[2]  = '{1'b1, 3'b010, 1, 3'b010, 2'b00, 0};
        tbl[3]  = '{1'b1, 3'b010, 1, 3'b010, 2'b01, 1};
        tbl[4]  = '{1'b1, 3'b010, 2, 3'b010, 2'b01, 0};
        tbl[5]  = '{1'b1, 3'b000, 8, 3'b000, 2'b00, 0};
        tbl[6]  = '{1'b1, 3'b010, 2, 3'b000, 2'b00, 0};
        tbl[7]  = '{1'b1, 3'b000, 2, 3'b000, 2'b00, 0};
        tbl[8]  = '{1'b1, 3'b010, 5, 3'b000, 2'b00, 0};
        tbl[9]  = '{1'b1, 3'b010, 1, 3'b010, 2'b00, 0};
        tbl[10] = '{1'b1, 3'b010, 1, 3'b010, 2'b01, 1};
        tbl[11] = '{1'b1, 3'b110, 6, 3'b110, 2'b01, 0};
        tbl[12] = '{1'b1, 3'b110, 1, 3'b110, 2'b00, 0};
        tbl[13] = '{1'b1, 3'b010, 6, 3'b010, 2'b00, -1};
        tbl[14] = '{1'b1, 3'b010, 1, 3'b010, 2'b01, -1};
        tbl[15] = '{1'b1, 3'b000, 8, 3'b000, 2'b00, -1};

        #2;
        for (int i = 0; i < 16; i++) begin
            rst_n = tbl[i].rst;
            btn   = tbl[i].b;
            if (!rst_n) model_reset();
            cnt = 0;
            for (int j = 0; j < tbl[i].n; j++) begin
                tick();
                if (up_pulse) cnt++;
            end
            check("tbl_center_lvl", center_lvl, tbl[i].lvl[0]);
            check("tbl_up_lvl", up_lvl, tbl[i].lvl[1]);
            check("tbl_down_lvl", down_lvl, tbl[i].lvl[2]);
            check("tbl_up_move", up_move, tbl[i].mv[0]);
            check("tbl_down_move", down_move, tbl[i].mv[1]);
            if (tbl[i].upp >= 0) check_int("tbl_up_pulses", cnt, tbl[i].upp);
        end

        // Async reset while the up counter is part-way through
        btn = 3'b100;
        for (int j = 0; j < 7; j++) tick();
        check("pre_rst_down_lvl", down_lvl, 1'b1);
        check("pre_rst_down_move", down_move, 1'b1);
        btn = 3'b110;
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_down_lvl", down_lvl, 1'b0);
        check("async_down_move", down_move, 1'b0);
        check("async_up_lvl", up_lvl, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        check("rel_up_lvl_early", up_lvl, 1'b0);
        check("rel_down_lvl_early", down_lvl, 1'b0);
        tick();
        check("rel_up_lvl", up_lvl, 1'b1);
        check("rel_down_lvl", down_lvl, 1'b1);
        tick();
        check("rel_up_pulse", up_pulse, 1'b1);
        check("rel_down_pulse", down_pulse, 1'b1);
        btn = 3'b000;
        for (int j = 0; j < 10; j++) tick();

        // Long center hold: repeat pulse positions relative to acceptance
        btn = 3'b001;
        for (int j = 0; j < 6; j++) tick();
        check("hold_center_lvl", center_lvl, 1'b1);
        pc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            expp = (k == 1) || (AR && k >= RD + 1 && ((k - RD - 1) % RR) == 0);
            check("rpt_position", center_pulse, expp);
            if (center_pulse) pc++;
        end
        check_int("rpt_count", pc, AR ? 8 : 1);
        btn = 3'b000;
        for (int j = 0; j < 6; j++) tick();
        check("release_center_lvl", center_lvl, 1'b0);
        pc = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (center_pulse) pc++;
        end
        check_int("post_release_pulses", pc, 0);

        // Random bouncing inputs with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(199, 0) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            for (int ch = 0; ch < 3; ch++) begin
                if ($urandom_range(7, 0) == 0) btn[ch] = ~btn[ch];
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
